sica_sched: RTL and testbench

- Top-level sequencer for one Simplex-FastICA window.
- Accepts the serial channel-major sample stream (DIM channels × SAMPLES words, channel 0 first) and writes it linearly into the sample memory.
- Then runs the deflation loop. For each component k, it alternates update-unit and orthogonalisation-unit passes until convergence or the MAX_ITER limit.
- Reports per-component convergence and a window-done pulse.

---
 rtl/sica_sched_if.sv | 54 +++++
 rtl/sica_sched.sv | 197 +++++++++++++++++++
 tb/tb_sica_sched.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sica_sched_if.sv
// Bundles the sample stream, sample-memory write port, update/orth unit
// handshakes and status outputs of the Simplex-FastICA window sequencer.
// Optional macro SICA_SCHED_TIMEOUT_EN adds the timeout_err status signal.
interface sica_sched_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SAMPLES    = 1024,
  parameter int DIM        = 5,
  parameter int MAX_ITER   = 16,
  parameter int ADDR_W     = $clog2(DIM * SAMPLES),
  parameter int COMP_W     = $clog2(DIM),
  parameter int ITER_W     = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1
);
  logic                  start;
  logic                  abort;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  upd_start;
  logic                  upd_done;
  logic                  converged;
  logic                  orth_start;
  logic                  orth_done;
  logic [COMP_W-1:0]     comp_idx;
  logic [ITER_W-1:0]     iter_idx;
  logic                  busy;
  logic                  window_done;
  logic [DIM-1:0]        conv_mask;
`ifdef SICA_SCHED_TIMEOUT_EN
  logic                  timeout_err;
`endif

  // Environment side: drives control, stream and unit completions.
  modport master (
`ifdef SICA_SCHED_TIMEOUT_EN
    input  timeout_err,
`endif
    output start, abort, in_valid, in_data, upd_done, converged, orth_done,
    input  in_ready, mem_we, mem_addr, mem_wdata, upd_start, orth_start,
    input  comp_idx, iter_idx, busy, window_done, conv_mask
  );

  // Sequencer side.
  modport slave (
`ifdef SICA_SCHED_TIMEOUT_EN
    output timeout_err,
`endif
    input  start, abort, in_valid, in_data, upd_done, converged, orth_done,
    output in_ready, mem_we, mem_addr, mem_wdata, upd_start, orth_start,
    output comp_idx, iter_idx, busy, window_done, conv_mask
  );
endinterface

// File: rtl/sica_sched.sv
// Simplex-FastICA window sequencer: loads the channel-major sample stream
// into sample memory, then runs the deflation loop (update + orth passes per
// component) and reports per-component convergence.
// Optional macro SICA_SCHED_TIMEOUT_EN bounds each unit wait to TIMEOUT cycles.
module sica_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int SAMPLES    = 1024,
  parameter int DIM        = 5,
  parameter int MAX_ITER   = 16,
  parameter int ADDR_W     = $clog2(DIM * SAMPLES),
  parameter int COMP_W     = $clog2(DIM),
  parameter int ITER_W     = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1
`ifdef SICA_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT  = 65535
`endif
) (
  input  logic         clk,
  input  logic         rst,
  sica_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_UPD, S_UPD_WAIT, S_ORTH, S_ORTH_WAIT, S_NEXT, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DIM * SAMPLES - 1);
  localparam logic [COMP_W-1:0] LAST_COMP = COMP_W'(DIM - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [COMP_W-1:0]     comp_q, comp_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic                  conv_flag_q, conv_flag_d;
  logic [DIM-1:0]        conv_mask_q, conv_mask_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

`ifdef SICA_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             tmo_hit;
  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
`endif

  // State and datapath registers.
  // NOTE: only flops live here, so every register has a reset value; the
  // sample memory itself is external and is never cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      comp_q      <= '0;
      iter_q      <= '0;
      conv_flag_q <= 1'b0;
      conv_mask_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef SICA_SCHED_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q     <= state_d;
      addr_q      <= addr_d;
      comp_q      <= comp_d;
      iter_q      <= iter_d;
      conv_flag_q <= conv_flag_d;
      conv_mask_q <= conv_mask_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef SICA_SCHED_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  // Next-state and counter update; abort overrides every transition.
  always_comb begin
    // NOTE: hold-by-default assignments keep this block free of latches.
    state_d     = state_q;
    addr_d      = addr_q;
    comp_d      = comp_q;
    iter_d      = iter_q;
    conv_flag_d = conv_flag_q;
    conv_mask_d = conv_mask_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef SICA_SCHED_TIMEOUT_EN
    timeout_err_d = timeout_err_q;
    // Counts cycles spent waiting; any non-wait state re-arms it, so it is
    // zero on entry to every UPD_WAIT/ORTH_WAIT.
    tmo_cnt_d = (state_q == S_UPD_WAIT || state_q == S_ORTH_WAIT)
                ? tmo_cnt_q + 1'b1 : '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_LOAD;
          addr_d      = '0;
          comp_d      = '0;
          iter_d      = '0;
          conv_mask_d = '0;
`ifdef SICA_SCHED_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = bus.in_data;
          addr_d      = addr_q + 1'b1;
          if (addr_q == LAST_ADDR) state_d = S_UPD;
        end
      end
      S_UPD: state_d = S_UPD_WAIT;
      S_UPD_WAIT: begin
        if (bus.upd_done) begin
          conv_flag_d = bus.converged;
          state_d     = S_ORTH;
        end
`ifdef SICA_SCHED_TIMEOUT_EN
        else if (tmo_hit) begin
          timeout_err_d       = 1'b1;
          conv_mask_d[comp_q] = 1'b0;
          state_d             = S_DONE;
        end
`endif
      end
      S_ORTH: state_d = S_ORTH_WAIT;
      S_ORTH_WAIT: begin
        if (bus.orth_done) begin
          if (conv_flag_q || iter_q == LAST_ITER) begin
            conv_mask_d[comp_q] = conv_flag_q;
            state_d             = S_NEXT;
          end else begin
            iter_d  = iter_q + 1'b1;
            state_d = S_UPD;
          end
        end
`ifdef SICA_SCHED_TIMEOUT_EN
        else if (tmo_hit) begin
          timeout_err_d       = 1'b1;
          conv_mask_d[comp_q] = 1'b0;
          state_d             = S_DONE;
        end
`endif
      end
      S_NEXT: begin
        if (comp_q == LAST_COMP) begin
          state_d = S_DONE;
        end else begin
          comp_d  = comp_q + 1'b1;
          iter_d  = '0;
          state_d = S_UPD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.abort && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      mem_we_d    = 1'b0;
      conv_mask_d = '0;
    end
  end

  // Outputs: pulses decoded from state, write port and indices from registers.
  always_comb begin
    bus.in_ready    = (state_q == S_LOAD);
    bus.upd_start   = (state_q == S_UPD);
    bus.orth_start  = (state_q == S_ORTH);
    bus.window_done = (state_q == S_DONE);
    bus.busy        = (state_q != S_IDLE);
    bus.mem_we      = mem_we_q;
    bus.mem_addr    = mem_addr_q;
    bus.mem_wdata   = mem_wdata_q;
    bus.comp_idx    = comp_q;
    bus.iter_idx    = iter_q;
    bus.conv_mask   = conv_mask_q;
`ifdef SICA_SCHED_TIMEOUT_EN
    bus.timeout_err = timeout_err_q;
`endif
  end

endmodule

// File: tb/tb_sica_sched.sv
// Self-checking bench for sica_sched (DIM=2, SAMPLES=4, MAX_ITER=3) with
// randomized stream gaps, convergence plans and unit latencies.
// Define SICA_SCHED_TIMEOUT_EN to also exercise the timeout (TIMEOUT=10).
module tb_sica_sched;
  localparam int DW       = 16;
  localparam int SAMPLES  = 4;
  localparam int DIM      = 2;
  localparam int MAX_ITER = 3;
  localparam int NWORDS   = DIM * SAMPLES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sica_sched_if #(.DATA_WIDTH(DW), .SAMPLES(SAMPLES), .DIM(DIM),
                  .MAX_ITER(MAX_ITER)) bus ();

`ifdef SICA_SCHED_TIMEOUT_EN
  sica_sched #(.DATA_WIDTH(DW), .SAMPLES(SAMPLES), .DIM(DIM),
               .MAX_ITER(MAX_ITER), .TIMEOUT(10))
    dut (.clk(clk), .rst(rst), .bus(bus));
`else
  sica_sched #(.DATA_WIDTH(DW), .SAMPLES(SAMPLES), .DIM(DIM),
               .MAX_ITER(MAX_ITER))
    dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int checks = 0;
  int errors = 0;

  // Reference data: convergence plan per (component, iteration) and memory.
  bit          plan [DIM][MAX_ITER];
  logic [DW-1:0] exp_mem [NWORDS];
  bit          resp_en  = 1'b1;
  bit          noise_en = 1'b0;

  // Observed activity, logged away from the active edge.
  int wr_addr[$];
  int wr_data[$];
  int upd_log[$];
  int orth_log[$];
  int wd_count = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_we) begin
        wr_addr.push_back(int'(bus.mem_addr));
        wr_data.push_back(int'(bus.mem_wdata));
      end
      if (bus.upd_start)   upd_log.push_back(int'(bus.comp_idx) * 16 + int'(bus.iter_idx));
      if (bus.orth_start)  orth_log.push_back(int'(bus.comp_idx) * 16 + int'(bus.iter_idx));
      if (bus.window_done) wd_count++;
    end
  end

  // Update unit model: answers each upd_start after 0..3 wait cycles.
  initial begin
    int c, i, d;
    forever begin
      @(negedge clk);
      if (resp_en && bus.upd_start) begin
        c = int'(bus.comp_idx);
        i = int'(bus.iter_idx);
        d = $urandom_range(0, 3);
        @(posedge clk);
        repeat (d) @(posedge clk);
        #1;
        bus.upd_done  = 1'b1;
        bus.converged = plan[c][i];
        @(posedge clk);
        #1;
        bus.upd_done  = 1'b0;
        bus.converged = 1'($urandom);
      end
    end
  end

  // Orth unit model; optionally raises a stray upd_done alongside orth_done.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (resp_en && bus.orth_start) begin
        d = $urandom_range(0, 3);
        @(posedge clk);
        repeat (d) @(posedge clk);
        #1;
        bus.orth_done = 1'b1;
        if (noise_en && ($urandom_range(0, 1) == 1)) begin
          bus.upd_done  = 1'b1;
          bus.converged = 1'($urandom);
        end
        @(posedge clk);
        #1;
        bus.orth_done = 1'b0;
        bus.upd_done  = 1'b0;
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // mode 0: values 1..N, valid held; 1: values 1..N, valid every other
  // cycle; 2: random values with random gaps.
  task automatic load_words(input int mode);
    bit ready_ok = 1'b1;
    for (int n = 0; n < NWORDS; n++) begin
      int gap;
      logic [DW-1:0] v;
      gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      v   = (mode == 2) ? DW'($urandom) : DW'(n + 1);
      exp_mem[n] = v;
      bus.in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      if (bus.in_ready !== 1'b1) ready_ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      @(posedge clk); #1;
    end
    bus.in_data = DW'(16'hDEAD);  // held valid: an extra word must be refused
    @(negedge clk);
    checks++;
    if (ready_ok !== 1'b1) begin
      errors++; $display("FAIL load_in_ready_high: in_ready dropped during load");
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL in_ready_after_last: got %0b want 0", bus.in_ready);
    end
    checks++;
    if (bus.upd_start !== 1'b1 || bus.comp_idx !== '0 || bus.iter_idx !== '0) begin
      errors++;
      $display("FAIL first_upd_start: upd_start=%0b comp=%0d iter=%0d want 1/0/0",
               bus.upd_start, bus.comp_idx, bus.iter_idx);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Full window: load, run deflation loop, compare against the plan.
  task automatic run_window(input int ld_mode, input int plan_mode,
                            input bit poke_start, input string name);
    int exp_seq[$];
    logic [DIM-1:0] exp_mask = '0;
    logic [DIM-1:0] got_mask = '0;
    bit seen = 1'b0;
    int wd0;
    int bad;

    for (int c = 0; c < DIM; c++)
      for (int i = 0; i < MAX_ITER; i++)
        plan[c][i] = (plan_mode == 0) ? 1'b1 :
                     (plan_mode == 1) ? 1'b0 : ($urandom_range(0, 2) == 0);
    for (int c = 0; c < DIM; c++) begin
      for (int i = 0; i < MAX_ITER; i++) begin
        exp_seq.push_back(c * 16 + i);
        if (plan[c][i]) begin
          exp_mask[c] = 1'b1;
          break;
        end
      end
    end

    wr_addr.delete(); wr_data.delete(); upd_log.delete(); orth_log.delete();
    wd0 = wd_count;
    do_start();
    load_words(ld_mode);

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (poke_start) bus.start = (cyc == 3);
      if (bus.window_done === 1'b1) begin
        seen     = 1'b1;
        got_mask = bus.conv_mask;
        break;
      end
    end
    bus.start = 1'b0;

    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s window_done: never seen within cycle budget", name);
    end
    checks++;
    if (got_mask !== exp_mask) begin
      errors++; $display("FAIL %s conv_mask: got %b want %b", name, got_mask, exp_mask);
    end

    bad = -1;
    for (int n = 0; n < wr_addr.size(); n++)
      if (bad < 0 && (wr_addr[n] != n || wr_data[n] != int'(exp_mem[n]))) bad = n;
    checks++;
    if (wr_addr.size() != NWORDS || bad >= 0) begin
      errors++;
      $display("FAIL %s mem_writes: got %0d writes, first bad index %0d, want %0d in order",
               name, wr_addr.size(), bad, NWORDS);
    end

    bad = -1;
    for (int n = 0; n < upd_log.size() && n < exp_seq.size(); n++)
      if (bad < 0 && upd_log[n] != exp_seq[n]) bad = n;
    checks++;
    if (upd_log.size() != exp_seq.size() || bad >= 0) begin
      errors++;
      $display("FAIL %s upd_start_seq: got %0d pulses, first bad %0d, want %0d pulses",
               name, upd_log.size(), bad, exp_seq.size());
    end

    bad = -1;
    for (int n = 0; n < orth_log.size() && n < exp_seq.size(); n++)
      if (bad < 0 && orth_log[n] != exp_seq[n]) bad = n;
    checks++;
    if (orth_log.size() != exp_seq.size() || bad >= 0) begin
      errors++;
      $display("FAIL %s orth_start_seq: got %0d pulses, first bad %0d, want %0d pulses",
               name, orth_log.size(), bad, exp_seq.size());
    end

    @(posedge clk); #1;
    checks++;
    if (wd_count != wd0 + 1 || bus.busy !== 1'b0 || bus.conv_mask !== exp_mask) begin
      errors++;
      $display("FAIL %s after_done: pulses=%0d busy=%0b mask=%b want 1/0/%b",
               name, wd_count - wd0, bus.busy, bus.conv_mask, exp_mask);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.upd_done = 1'b0; bus.converged = 1'b0; bus.orth_done = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.mem_we, bus.upd_start, bus.orth_start,
         bus.busy, bus.window_done} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: some control output nonzero in reset");
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.comp_idx, bus.iter_idx, bus.conv_mask} !== '0) begin
      errors++; $display("FAIL reset_values: addr=%0h data=%0h comp=%0d iter=%0d mask=%b",
                         bus.mem_addr, bus.mem_wdata, bus.comp_idx, bus.iter_idx, bus.conv_mask);
    end
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%0b in_ready=%0b want 0/0",
                         bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_abort();
    bit seen = 1'b0;
    int wd0 = wd_count;
    for (int i = 0; i < MAX_ITER; i++) begin
      plan[0][i] = 1'b1;
      plan[1][i] = 1'b0;
    end
    do_start();
    load_words(2);
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      if (bus.upd_start === 1'b1 && bus.comp_idx === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || bus.conv_mask !== 2'b01) begin
      errors++; $display("FAIL abort_setup: comp1 seen=%0b mask=%b want 1/01", seen, bus.conv_mask);
    end
    @(posedge clk); #1;
    bus.abort = 1'b1;   // state is UPD_WAIT of comp 1 during this cycle
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_we !== 1'b0 || bus.conv_mask !== '0 ||
        bus.upd_start !== 1'b0 || bus.orth_start !== 1'b0) begin
      errors++; $display("FAIL abort_idle: busy=%0b we=%0b mask=%b want 0/0/00",
                         bus.busy, bus.mem_we, bus.conv_mask);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (wd_count != wd0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: window_done pulses=%0d busy=%0b want 0/0",
                         wd_count - wd0, bus.busy);
    end
    run_window(2, 2, 1'b0, "after_abort");
  endtask

  task automatic test_reset_midwindow();
    int wd0 = wd_count;
    int n_upd;
    bit stayed_idle = 1'b1;
    for (int c = 0; c < DIM; c++)
      for (int i = 0; i < MAX_ITER; i++) plan[c][i] = 1'b0;
    do_start();
    load_words(0);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.comp_idx !== '0 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL async_reset_now: busy=%0b comp=%0d we=%0b want 0/0/0",
                         bus.busy, bus.comp_idx, bus.mem_we);
    end
    #1 rst = 1'b0;
    n_upd = upd_log.size();
    repeat (8) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) stayed_idle = 1'b0;
    end
    #1;
    checks++;
    if (!stayed_idle || upd_log.size() != n_upd || wd_count != wd0) begin
      errors++; $display("FAIL async_reset_ignore_done: idle=%0b new_upd=%0d done=%0d want 1/0/0",
                         stayed_idle, upd_log.size() - n_upd, wd_count - wd0);
    end
  endtask

`ifdef SICA_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int cycles = 0;
    bit seen = 1'b0;
    resp_en = 1'b0;
    do_start();
    load_words(0);   // returns one step into the first UPD_WAIT cycle
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      cycles++;
      if (bus.window_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || cycles != 11) begin
      errors++; $display("FAIL timeout_latency: done seen=%0b after %0d cycles want 11", seen, cycles);
    end
    checks++;
    if (bus.timeout_err !== 1'b1 || bus.conv_mask !== '0) begin
      errors++; $display("FAIL timeout_status: err=%0b mask=%b want 1/00",
                         bus.timeout_err, bus.conv_mask);
    end
    do_start();
    @(negedge clk);
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: got %0b want 0", bus.timeout_err);
    end
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    resp_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    run_window(0, 0, 1'b0, "held_all_converge");
    run_window(1, 1, 1'b0, "toggled_never_converge");
    noise_en = 1'b1;
    for (int r = 0; r < 4; r++) run_window(2, 2, 1'b1, "random");
    test_abort();
    test_reset_midwindow();
`ifdef SICA_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
